// File: rtl/classify_pkg.sv
// Shared defaults, index width and FSM state encoding for classify_scheduler.
// Optional margin output is enabled with CLASSIFY_MARGIN_EN (see top2_tracker).
package classify_pkg;

    localparam int unsigned NUM_SIZE_DEF    = 26;
    localparam int unsigned NUM_CLASSES_DEF = 10;
    localparam int unsigned IDX_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/top2_tracker.sv
// Running maximum with first-index tie-break; with CLASSIFY_MARGIN_EN it also
// tracks the runner-up and registers the winner-minus-runner-up margin.
module top2_tracker
    import classify_pkg::*;
#(
    parameter int unsigned NUM_SIZE = NUM_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                accept,
    input  logic                first,
    input  logic [IDX_W-1:0]    acc_idx,
    input  logic [NUM_SIZE-1:0] score,
    output logic [IDX_W-1:0]    max_idx,
    output logic [NUM_SIZE-1:0] max_score
`ifdef CLASSIFY_MARGIN_EN
    ,
    output logic [NUM_SIZE-1:0] margin
`endif
);

    logic take;

    // Strictly-greater replacement keeps the lower index on ties.
    always_comb begin
        take = accept && (first || (score > max_score));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_idx   <= '0;
            max_score <= '0;
        end else if (clear) begin
            max_idx   <= '0;
            max_score <= '0;
        end else if (take) begin
            max_idx   <= acc_idx;
            max_score <= score;
        end
    end

`ifdef CLASSIFY_MARGIN_EN
    logic [NUM_SIZE-1:0] second_q;
    logic [NUM_SIZE-1:0] second_nxt;
    logic [NUM_SIZE-1:0] max_nxt;

    // A displaced winner becomes the runner-up; a losing score (ties included)
    // competes only for the runner-up slot.
    always_comb begin
        max_nxt    = take ? score : max_score;
        second_nxt = second_q;
        if (take) begin
            second_nxt = first ? '0 : max_score;
        end else if (accept && (score > second_q)) begin
            second_nxt = score;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_q <= '0;
            margin   <= '0;
        end else if (clear) begin
            second_q <= '0;
            margin   <= '0;
        end else if (accept) begin
            second_q <= second_nxt;
            margin   <= max_nxt - second_nxt;
        end
    end
`endif

endmodule

// File: rtl/classify_scheduler.sv
// Frame scheduler: accepts NUM_CLASSES scores, reports argmax index and score.
// Define CLASSIFY_MARGIN_EN to add the Margin output (winner minus runner-up).
module classify_scheduler
    import classify_pkg::*;
#(
    parameter int unsigned NUM_SIZE    = NUM_SIZE_DEF,
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF
) (
    input  logic                Clk,
    input  logic                GlobalReset_n,
    input  logic                Start,
    input  logic                ScoreValid,
    input  logic [NUM_SIZE-1:0] Score,
    output logic                ScoreReady,
    input  logic                Abort,
    output logic                ResultValid,
    input  logic                ResultReady,
    output logic [IDX_W-1:0]    Index,
    output logic [NUM_SIZE-1:0] MaxScore,
    output logic                Busy
`ifdef CLASSIFY_MARGIN_EN
    ,
    output logic [NUM_SIZE-1:0] Margin
`endif
);

    localparam int unsigned      CNT_W    = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_CLASSES);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             clear;
    logic             accept;
    logic             first;
    logic [IDX_W-1:0] acc_idx;

    // Reset assertion is asynchronous; release is retimed so Start is
    // honoured from the second rising edge after deassertion.
    always_ff @(posedge Clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_comb begin
        clear   = (state_q == ST_IDLE) && run_q && Start;
        accept  = (state_q == ST_LOAD) && ScoreValid && ScoreReady && !Abort;
        first   = (cnt_q == '0);
        acc_idx = IDX_W'(cnt_q);
    end

    always_ff @(posedge Clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ScoreReady  <= 1'b0;
            ResultValid <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_q    <= ST_LOAD;
                        cnt_q      <= '0;
                        ScoreReady <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (Abort) begin
                        state_q    <= ST_IDLE;
                        ScoreReady <= 1'b0;
                        Busy       <= 1'b0;
                    end else if (accept) begin
                        if (cnt_q != FULL_CNT) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_q     <= ST_RESULT;
                            ScoreReady  <= 1'b0;
                            ResultValid <= 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    if (ResultReady) begin
                        state_q     <= ST_IDLE;
                        ResultValid <= 1'b0;
                        Busy        <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ScoreReady  <= 1'b0;
                    ResultValid <= 1'b0;
                    Busy        <= 1'b0;
                end
            endcase
        end
    end

    top2_tracker #(
        .NUM_SIZE(NUM_SIZE)
    ) u_top2 (
        .clk       (Clk),
        .rst_n     (GlobalReset_n),
        .clear     (clear),
        .accept    (accept),
        .first     (first),
        .acc_idx   (acc_idx),
        .score     (Score),
        .max_idx   (Index),
        .max_score (MaxScore)
`ifdef CLASSIFY_MARGIN_EN
        ,
        .margin    (Margin)
`endif
    );

endmodule

// File: tb/tb_classify_scheduler.sv
// Directed bench for classify_scheduler with a queue-based reference model.
module tb_classify_scheduler;

    localparam int unsigned W  = 26;
    localparam int unsigned NC = 10;

    logic         Clk           = 1'b0;
    logic         GlobalReset_n = 1'b0;
    logic         Start         = 1'b0;
    logic         ScoreValid    = 1'b0;
    logic         Abort         = 1'b0;
    logic         ResultReady   = 1'b0;
    logic [W-1:0] Score         = '0;
    logic         ScoreReady;
    logic         ResultValid;
    logic         Busy;
    logic [3:0]   Index;
    logic [W-1:0] MaxScore;
`ifdef CLASSIFY_MARGIN_EN
    logic [W-1:0] Margin;
`endif

    int n_vec = 0;
    int n_err = 0;

    classify_scheduler #(
        .NUM_SIZE    (W),
        .NUM_CLASSES (NC)
    ) dut (
        .Clk           (Clk),
        .GlobalReset_n (GlobalReset_n),
        .Start         (Start),
        .ScoreValid    (ScoreValid),
        .Score         (Score),
        .ScoreReady    (ScoreReady),
        .Abort         (Abort),
        .ResultValid   (ResultValid),
        .ResultReady   (ResultReady),
        .Index         (Index),
        .MaxScore      (MaxScore),
        .Busy          (Busy)
`ifdef CLASSIFY_MARGIN_EN
        ,
        .Margin        (Margin)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=loading 2=result; m_q holds accepted scores.
    int          m_phase = 0;
    int          m_edges = 0;
    bit          m_fresh = 1'b1;
    int unsigned m_q[$];

    initial forever begin
        @(posedge Clk or negedge GlobalReset_n);
        if (!GlobalReset_n) begin
            m_phase = 0;
            m_edges = 0;
            m_fresh = 1'b1;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (Start && m_edges >= 1) begin
                    m_phase = 1;
                    m_fresh = 1'b0;
                    m_q.delete();
                end
                1: if (Abort) begin
                    m_phase = 0;
                end else if (ScoreValid) begin
                    m_q.push_back(int'(Score));
                    if (m_q.size() == NC) m_phase = 2;
                end
                2: if (ResultReady) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_edges++;
        end
    end

    function automatic void model_result(output int idx, output int unsigned mx, output int unsigned mg);
        int unsigned ru   = 0;
        bit          have = 1'b0;
        idx = 0;
        mx  = m_q[0];
        for (int i = 1; i < m_q.size(); i++) begin
            if (m_q[i] > mx) begin
                mx  = m_q[i];
                idx = i;
            end
        end
        for (int i = 0; i < m_q.size(); i++) begin
            if (i != idx && (!have || m_q[i] > ru)) begin
                ru   = m_q[i];
                have = 1'b1;
            end
        end
        mg = mx - ru;
    endfunction

    always @(negedge Clk) begin
        int          ei;
        int unsigned em;
        int unsigned eg;
        check("score_ready", ScoreReady, m_phase == 1);
        check("result_valid", ResultValid, m_phase == 2);
        check("busy", Busy, m_phase != 0);
        if (m_phase == 2) begin
            model_result(ei, em, eg);
            check("model_index", Index, ei);
            check("model_max", MaxScore, em);
`ifdef CLASSIFY_MARGIN_EN
            check("model_margin", Margin, eg);
`endif
        end else if (m_fresh) begin
            check("reset_index", Index, 0);
            check("reset_max", MaxScore, 0);
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic start_frame;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic feed(input int unsigned s[NC]);
        for (int i = 0; i < NC; i++) begin
            ScoreValid = 1'b1;
            Score      = W'(s[i]);
            tick();
        end
        ScoreValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int unsigned v[NC];
        int unsigned s12[12];

        repeat (3) tick();

        // Frame 1: Start held from release; ignored on edge 1, honoured on edge 2.
        GlobalReset_n = 1'b1;
        Start         = 1'b1;
        ResultReady   = 1'b1;
        tick();
        check("sync_edge1_busy", Busy, 0);
        tick();
        check("sync_edge2_busy", Busy, 1);
        Start = 1'b0;
        v = '{5, 3, 9, 1, 9, 0, 2, 8, 7, 4};
        feed(v);
        check("t1_latency_valid", ResultValid, 1);
        check("t1_index", Index, 2);
        check("t1_max", MaxScore, 9);
`ifdef CLASSIFY_MARGIN_EN
        check("t1_margin", Margin, 0);
`endif
        tick();
        check("t1_valid_drop", ResultValid, 0);
        check("t1_idle", Busy, 0);

        // All zeros.
        v = '{default: 0};
        start_frame();
        feed(v);
        check("t2_index", Index, 0);
        check("t2_max", MaxScore, 0);
        tick();

        // Ascending with back-pressure; Start/ScoreValid ignored in RESULT.
        ResultReady = 1'b0;
        for (int i = 0; i < NC; i++) v[i] = i + 1;
        start_frame();
        feed(v);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", ResultValid, 1);
            check("t3_hold_index", Index, 9);
            check("t3_hold_max", MaxScore, 10);
            check("t3_hold_ready", ScoreReady, 0);
            Start      = 1'b1;
            ScoreValid = 1'b1;
            Score      = W'(50);
            tick();
        end
        Start       = 1'b0;
        ScoreValid  = 1'b0;
        ResultReady = 1'b1;
        check("t3_last_valid", ResultValid, 1);
        tick();
        check("t3_idle_busy", Busy, 0);
        check("t3_idle_valid", ResultValid, 0);
        tick();

        // Abort after 4 scores (with a simultaneous valid score), then full frame.
        start_frame();
        v = '{3, 7, 2, 8, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            ScoreValid = 1'b1;
            Score      = W'(v[i]);
            tick();
        end
        Abort      = 1'b1;
        ScoreValid = 1'b1;
        Score      = W'(100);
        tick();
        Abort      = 1'b0;
        ScoreValid = 1'b0;
        check("t4_abort_busy", Busy, 0);
        check("t4_abort_valid", ResultValid, 0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("t4_idle_abort_busy", Busy, 0);
        v    = '{default: 0};
        v[6] = 67108863;
        start_frame();
        feed(v);
        check("t4_index", Index, 6);
        check("t4_max", MaxScore, 67108863);
`ifdef CLASSIFY_MARGIN_EN
        check("t4_margin", Margin, 67108863);
`endif
        tick();

        // Asynchronous reset after 7 scores, then a fresh frame.
        start_frame();
        for (int i = 0; i < 7; i++) begin
            ScoreValid = 1'b1;
            Score      = W'(i + 20);
            tick();
        end
        ScoreValid = 1'b0;
        #2 GlobalReset_n = 1'b0;
        #1;
        check("t5_rst_ready", ScoreReady, 0);
        check("t5_rst_valid", ResultValid, 0);
        check("t5_rst_busy", Busy, 0);
        check("t5_rst_index", Index, 0);
        check("t5_rst_max", MaxScore, 0);
        tick();
        GlobalReset_n = 1'b1;
        tick();
        start_frame();
        check("t5_restart_busy", Busy, 1);
        v = '{4, 0, 11, 12, 5, 12, 3, 1, 0, 2};
        feed(v);
        check("t5_index", Index, 3);
        check("t5_max", MaxScore, 12);
`ifdef CLASSIFY_MARGIN_EN
        check("t5_margin", Margin, 0);
`endif
        tick();

        // ScoreValid held for 12 cycles: only the first 10 count.
        ResultReady = 1'b0;
        s12 = '{2, 9, 4, 9, 1, 3, 8, 0, 6, 5, 20, 30};
        start_frame();
        for (int i = 0; i < 12; i++) begin
            ScoreValid = 1'b1;
            Score      = W'(s12[i]);
            Start      = (i >= 10);
            tick();
        end
        ScoreValid = 1'b0;
        Start      = 1'b0;
        check("t6_valid", ResultValid, 1);
        check("t6_index", Index, 1);
        check("t6_max", MaxScore, 9);
        check("t6_ready", ScoreReady, 0);
        ResultReady = 1'b1;
        tick();
        check("t6_idle_busy", Busy, 0);
        tick();
        check("t6_still_idle", Busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/classify_scheduler.md
CLASSIFY_SCHEDULER -- requirements
Module: classify_scheduler

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 26: score width in bits, unsigned.
REQ-002 SHALL have parameter NUM_CLASSES, default 10: scores per frame, range 2..16.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port GlobalReset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1: request to begin a frame.
REQ-006 SHALL have port ScoreValid, input, 1: Score is valid this cycle.
REQ-007 SHALL have port Score, input, NUM_SIZE: next class score, in class order 0..NUM_CLASSES-1.
REQ-008 SHALL have port ScoreReady, output, 1: block accepts Score this cycle.
REQ-009 SHALL have port Abort, input, 1: discard the current frame.
REQ-010 SHALL have port ResultValid, output, 1: Index and MaxScore are valid.
REQ-011 SHALL have port ResultReady, input, 1: consumer takes the result.
REQ-012 SHALL have port Index, output, 4: winning class index.
REQ-013 SHALL have port MaxScore, output, NUM_SIZE: winning score.
REQ-014 SHALL have port Busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD and RESULT.
REQ-016 IDLE: SHALL hold ScoreReady=0; Start=1 SHALL move to LOAD next cycle and clear the running max, index and count.
REQ-017 LOAD: SHALL hold ScoreReady=1; a score is accepted on ScoreValid&&ScoreReady.
REQ-018 Each accepted score SHALL replace the running max, and its count SHALL become the running index, only if it is strictly greater (unsigned) than the running max; ties SHALL keep the lower index.
REQ-019 The first accepted score of a frame SHALL be taken unconditionally as the running max at index 0.
REQ-020 The accept counter SHALL be ceil(log2(NUM_CLASSES+1)) bits wide and SHALL never wrap.
REQ-021 The accept cycle of score NUM_CLASSES-1 SHALL transition to RESULT; ResultValid SHALL rise the next cycle (latency 1 from the last accept).
REQ-022 RESULT: SHALL hold ScoreReady=0; Index and MaxScore SHALL stay stable while ResultValid=1 and ResultReady=0.
REQ-023 ResultValid&&ResultReady SHALL return the FSM to IDLE next cycle and drop ResultValid.
REQ-024 Start SHALL be ignored in LOAD and RESULT; ScoreValid SHALL be ignored in IDLE and RESULT.
REQ-025 Abort=1 in LOAD SHALL return the FSM to IDLE next cycle without asserting ResultValid; Abort has priority over a simultaneous score accept.
REQ-026 Abort SHALL be ignored in IDLE and RESULT.

Reset
REQ-027 Asserting GlobalReset_n=0 at any time, including mid-frame, SHALL immediately force IDLE, ScoreReady=0, ResultValid=0, Busy=0, Index=0, MaxScore=0 and count=0.
REQ-028 Release SHALL be synchronised internally; the first Start is honoured on the second rising edge after deassertion.

Configuration
REQ-029 With macro CLASSIFY_MARGIN_EN defined, SHALL add output Margin, width NUM_SIZE: winner score minus runner-up score, registered and valid with ResultValid.
REQ-030 The runner-up SHALL be the highest score not selected as winner; a score equal to the winner SHALL yield Margin=0.
REQ-031 Without CLASSIFY_MARGIN_EN, the Margin port and the runner-up logic SHALL be absent.

Structure
REQ-032 Package classify_pkg SHALL hold the NUM_SIZE and NUM_CLASSES defaults, the index width constant (4) and the FSM state enum.
REQ-033 Running-max and runner-up update logic SHALL live in sub-module top2_tracker; the FSM, counter and handshake logic SHALL stay in classify_scheduler.

Verification
REQ-034 Scores 5,3,9,1,9,0,2,8,7,4 with ResultReady=1 -> Index=2, MaxScore=9, ResultValid 1 cycle after the 10th accept; with the macro, Margin=0.
REQ-035 All ten scores 0 -> Index=0, MaxScore=0.
REQ-036 Scores 1..10 ascending with ResultReady held low for 5 cycles -> Index=9, MaxScore=10 stable all 5 cycles, ScoreReady=0; IDLE the cycle after ResultReady=1.
REQ-037 Abort after 4 scores, then a new frame of 2^26-1 at class 6 and 0 elsewhere -> no result for the aborted frame; Index=6, MaxScore=67108863.
REQ-038 GlobalReset_n pulsed low after 7 scores -> all outputs 0 asynchronously; the next full frame (max 12 at class 3) -> Index=3.
REQ-039 ScoreValid held high for 12 cycles in a frame -> exactly 10 accepted; ScoreValid and Start ignored while in RESULT.
